// File: rtl/msrh_pkg.sv
// Shared sizing and types for the ROB commit controller.
// The pointer width is the entry-index width plus one wrap bit.
package msrh_pkg;

    localparam int unsigned CMT_ENTRY_SIZE = 8;
    localparam int unsigned DISP_SIZE      = 4;
    localparam int unsigned CMT_IDX_W      = $clog2(CMT_ENTRY_SIZE);
    localparam int unsigned CMT_ID_W       = CMT_IDX_W + 1;
    localparam int unsigned PERF_CNT_W     = 32;

    typedef logic [CMT_ID_W-1:0]  cmt_id_t;
    typedef logic [CMT_IDX_W-1:0] cmt_idx_t;
    typedef logic [DISP_SIZE-1:0] grp_id_t;

    // Entry index carried in the low bits of a commit ID.
    function automatic cmt_idx_t cmt_idx(input cmt_id_t id);
        return id[CMT_IDX_W-1:0];
    endfunction

endpackage

// File: rtl/msrh_wrap_ptr.sv
// Wrapping ROB pointer: the index sits in the low bits and the wrap flag in the MSB.
// clear has priority over inc; reset has priority over both.
module msrh_wrap_ptr
    import msrh_pkg::*;
(
    input  logic    i_clk,
    input  logic    i_reset,
    input  logic    inc,
    input  logic    clear,
    output cmt_id_t ptr
);

    cmt_id_t ptr_q;
    cmt_id_t ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (clear) begin
            ptr_d = '0;
        end else if (inc) begin
            ptr_d = ptr_q + CMT_ID_W'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr = ptr_q;

endmodule

// File: rtl/msrh_rob_cmt_ctrl.sv
// ROB commit controller: allocates block IDs at dispatch and retires blocks in order.
// Optional saturating perf counters are built when MSRH_ROB_CMT_PERF_EN is defined.
module msrh_rob_cmt_ctrl
    import msrh_pkg::*;
(
    input  logic                                     i_clk,
    input  logic                                     i_reset,
    input  logic                                     i_disp_valid,
    input  logic [DISP_SIZE-1:0]                     i_disp_grp_id,
    output logic                                     o_disp_ready,
    output logic [CMT_ID_W-1:0]                      o_alloc_cmt_id,
    output logic [CMT_ENTRY_SIZE-1:0]                o_entry_load,
    input  logic [CMT_ENTRY_SIZE-1:0]                i_entry_all_done,
    input  logic [CMT_ENTRY_SIZE-1:0][DISP_SIZE-1:0] i_entry_grp_id,
    input  logic                                     i_commit_stall,
    input  logic                                     i_flush,
    output logic                                     o_commit_valid,
    output logic [CMT_ID_W-1:0]                      o_commit_cmt_id,
    output logic [DISP_SIZE-1:0]                     o_commit_grp_id,
    output logic [CMT_ENTRY_SIZE-1:0]                o_commit_finish,
`ifdef MSRH_ROB_CMT_PERF_EN
    output logic [PERF_CNT_W-1:0]                    o_perf_commit_cnt,
    output logic [PERF_CNT_W-1:0]                    o_perf_full_stall_cnt,
    output logic [PERF_CNT_W-1:0]                    o_perf_head_wait_cnt,
`endif
    output logic                                     o_rob_empty,
    output logic                                     o_rob_full
);

    cmt_id_t  r_in_ptr;
    cmt_id_t  r_out_ptr;
    cmt_idx_t in_idx;
    cmt_idx_t out_idx;
    logic     disp_fire;

    msrh_wrap_ptr u_in_ptr (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .inc     (disp_fire),
        .clear   (i_flush),
        .ptr     (r_in_ptr)
    );

    msrh_wrap_ptr u_out_ptr (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .inc     (o_commit_valid),
        .clear   (i_flush),
        .ptr     (r_out_ptr)
    );

    // i_disp_grp_id is stored by the entry itself; it does not affect control here.
    logic unused_grp;
    assign unused_grp = ^i_disp_grp_id;

    always_comb begin
        in_idx          = cmt_idx(r_in_ptr);
        out_idx         = cmt_idx(r_out_ptr);
        o_rob_empty     = (r_in_ptr == r_out_ptr);
        o_rob_full      = (in_idx == out_idx) &&
                          (r_in_ptr[CMT_ID_W-1] != r_out_ptr[CMT_ID_W-1]);
        o_disp_ready    = !o_rob_full && !i_flush;
        disp_fire       = i_disp_valid && o_disp_ready;
        o_alloc_cmt_id  = r_in_ptr;
        o_entry_load    = '0;
        if (disp_fire) begin
            o_entry_load = CMT_ENTRY_SIZE'(1) << in_idx;
        end

        // A slot freed by this commit only becomes usable next cycle.
        o_commit_valid  = !o_rob_empty && i_entry_all_done[out_idx] &&
                          !i_commit_stall && !i_flush;
        o_commit_cmt_id = r_out_ptr;
        o_commit_grp_id = i_entry_grp_id[out_idx];
        o_commit_finish = '0;
        if (o_commit_valid) begin
            o_commit_finish = CMT_ENTRY_SIZE'(1) << out_idx;
        end
    end

`ifdef MSRH_ROB_CMT_PERF_EN
    logic [PERF_CNT_W-1:0] perf_commit_cnt_q, perf_commit_cnt_d;
    logic [PERF_CNT_W-1:0] perf_full_stall_cnt_q, perf_full_stall_cnt_d;
    logic [PERF_CNT_W-1:0] perf_head_wait_cnt_q, perf_head_wait_cnt_d;

    // Saturating event counters; flush leaves them untouched.
    always_comb begin
        perf_commit_cnt_d     = perf_commit_cnt_q;
        perf_full_stall_cnt_d = perf_full_stall_cnt_q;
        perf_head_wait_cnt_d  = perf_head_wait_cnt_q;
        if (o_commit_valid && (perf_commit_cnt_q != '1)) begin
            perf_commit_cnt_d = perf_commit_cnt_q + PERF_CNT_W'(1);
        end
        if (i_disp_valid && o_rob_full && (perf_full_stall_cnt_q != '1)) begin
            perf_full_stall_cnt_d = perf_full_stall_cnt_q + PERF_CNT_W'(1);
        end
        if (!o_rob_empty && !o_commit_valid && (perf_head_wait_cnt_q != '1)) begin
            perf_head_wait_cnt_d = perf_head_wait_cnt_q + PERF_CNT_W'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            perf_commit_cnt_q     <= '0;
            perf_full_stall_cnt_q <= '0;
            perf_head_wait_cnt_q  <= '0;
        end else begin
            perf_commit_cnt_q     <= perf_commit_cnt_d;
            perf_full_stall_cnt_q <= perf_full_stall_cnt_d;
            perf_head_wait_cnt_q  <= perf_head_wait_cnt_d;
        end
    end

    assign o_perf_commit_cnt     = perf_commit_cnt_q;
    assign o_perf_full_stall_cnt = perf_full_stall_cnt_q;
    assign o_perf_head_wait_cnt  = perf_head_wait_cnt_q;
`endif

endmodule

// File: tb/tb_msrh_rob_cmt_ctrl.sv
// Directed self-checking bench for msrh_rob_cmt_ctrl (8 entries, 4-wide groups).
module tb_msrh_rob_cmt_ctrl;
    import msrh_pkg::*;

    logic                                     i_clk;
    logic                                     i_reset;
    logic                                     i_disp_valid;
    logic [DISP_SIZE-1:0]                     i_disp_grp_id;
    logic                                     o_disp_ready;
    logic [CMT_ID_W-1:0]                      o_alloc_cmt_id;
    logic [CMT_ENTRY_SIZE-1:0]                o_entry_load;
    logic [CMT_ENTRY_SIZE-1:0]                i_entry_all_done;
    logic [CMT_ENTRY_SIZE-1:0][DISP_SIZE-1:0] i_entry_grp_id;
    logic                                     i_commit_stall;
    logic                                     i_flush;
    logic                                     o_commit_valid;
    logic [CMT_ID_W-1:0]                      o_commit_cmt_id;
    logic [DISP_SIZE-1:0]                     o_commit_grp_id;
    logic [CMT_ENTRY_SIZE-1:0]                o_commit_finish;
`ifdef MSRH_ROB_CMT_PERF_EN
    logic [PERF_CNT_W-1:0]                    o_perf_commit_cnt;
    logic [PERF_CNT_W-1:0]                    o_perf_full_stall_cnt;
    logic [PERF_CNT_W-1:0]                    o_perf_head_wait_cnt;
`endif
    logic                                     o_rob_empty;
    logic                                     o_rob_full;

    int checks;
    int failures;

    msrh_rob_cmt_ctrl dut (
        .i_clk                 (i_clk),
        .i_reset               (i_reset),
        .i_disp_valid          (i_disp_valid),
        .i_disp_grp_id         (i_disp_grp_id),
        .o_disp_ready          (o_disp_ready),
        .o_alloc_cmt_id        (o_alloc_cmt_id),
        .o_entry_load          (o_entry_load),
        .i_entry_all_done      (i_entry_all_done),
        .i_entry_grp_id        (i_entry_grp_id),
        .i_commit_stall        (i_commit_stall),
        .i_flush               (i_flush),
        .o_commit_valid        (o_commit_valid),
        .o_commit_cmt_id       (o_commit_cmt_id),
        .o_commit_grp_id       (o_commit_grp_id),
        .o_commit_finish       (o_commit_finish),
`ifdef MSRH_ROB_CMT_PERF_EN
        .o_perf_commit_cnt     (o_perf_commit_cnt),
        .o_perf_full_stall_cnt (o_perf_full_stall_cnt),
        .o_perf_head_wait_cnt  (o_perf_head_wait_cnt),
`endif
        .o_rob_empty           (o_rob_empty),
        .o_rob_full            (o_rob_full)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic test_reset();
        i_reset = 1'b1; i_disp_valid = 1'b0; i_disp_grp_id = '0;
        i_entry_all_done = '0; i_commit_stall = 1'b0; i_flush = 1'b0;
        for (int k = 0; k < CMT_ENTRY_SIZE; k++) i_entry_grp_id[k] = DISP_SIZE'(k + 1);
        step(); step();
        i_reset = 1'b0;
        #1;
        checks++; if (o_rob_empty !== 1'b1) begin failures++; $display("FAIL reset_empty got=%b exp=1", o_rob_empty); end
        checks++; if (o_rob_full !== 1'b0) begin failures++; $display("FAIL reset_full got=%b exp=0", o_rob_full); end
        checks++; if (o_disp_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", o_disp_ready); end
        checks++; if (o_commit_valid !== 1'b0) begin failures++; $display("FAIL reset_cvalid got=%b exp=0", o_commit_valid); end
        checks++; if (o_commit_finish !== 8'h00) begin failures++; $display("FAIL reset_finish got=%h exp=00", o_commit_finish); end
        checks++; if (o_entry_load !== 8'h00) begin failures++; $display("FAIL reset_load got=%h exp=00", o_entry_load); end
    endtask

    task automatic test_dispatch();
        i_disp_valid = 1'b1; i_disp_grp_id = 4'b0011;
        #1;
        checks++; if (o_entry_load !== 8'h01) begin failures++; $display("FAIL disp_load got=%h exp=01", o_entry_load); end
        checks++; if (o_alloc_cmt_id !== 4'h0) begin failures++; $display("FAIL disp_alloc0 got=%h exp=0", o_alloc_cmt_id); end
        step();
        i_disp_valid = 1'b0;
        #1;
        checks++; if (o_alloc_cmt_id !== 4'h1) begin failures++; $display("FAIL disp_alloc1 got=%h exp=1", o_alloc_cmt_id); end
        checks++; if (o_rob_empty !== 1'b0) begin failures++; $display("FAIL disp_empty got=%b exp=0", o_rob_empty); end
    endtask

    task automatic test_full();
        i_disp_valid = 1'b1;
        for (int k = 1; k < 8; k++) step();
        i_disp_valid = 1'b0;
        #1;
        checks++; if (o_rob_full !== 1'b1) begin failures++; $display("FAIL full_flag got=%b exp=1", o_rob_full); end
        checks++; if (o_disp_ready !== 1'b0) begin failures++; $display("FAIL full_ready got=%b exp=0", o_disp_ready); end
        i_disp_valid = 1'b1;
        #1;
        checks++; if (o_entry_load !== 8'h00) begin failures++; $display("FAIL full_load got=%h exp=00", o_entry_load); end
        step();
        i_disp_valid = 1'b0;
        #1;
        checks++; if (o_alloc_cmt_id !== 4'h8) begin failures++; $display("FAIL full_inptr got=%h exp=8", o_alloc_cmt_id); end
        checks++; if (o_commit_cmt_id !== 4'h0) begin failures++; $display("FAIL full_outptr got=%h exp=0", o_commit_cmt_id); end
        checks++; if (o_rob_full !== 1'b1) begin failures++; $display("FAIL full_hold got=%b exp=1", o_rob_full); end
    endtask

    task automatic test_commit();
        for (int k = 0; k < 3; k++) begin
            i_entry_all_done = CMT_ENTRY_SIZE'(1) << k;
            step();
        end
        i_entry_all_done = 8'h10;
        #1;
        checks++; if (o_commit_valid !== 1'b0) begin failures++; $display("FAIL commit_notdone got=%b exp=0", o_commit_valid); end
        i_entry_all_done = 8'h08; i_commit_stall = 1'b1;
        #1;
        checks++; if (o_commit_valid !== 1'b0) begin failures++; $display("FAIL commit_stall got=%b exp=0", o_commit_valid); end
        i_commit_stall = 1'b0;
        #1;
        checks++; if (o_commit_valid !== 1'b1) begin failures++; $display("FAIL commit_valid got=%b exp=1", o_commit_valid); end
        checks++; if (o_commit_finish !== 8'h08) begin failures++; $display("FAIL commit_finish got=%h exp=08", o_commit_finish); end
        checks++; if (o_commit_cmt_id !== 4'h3) begin failures++; $display("FAIL commit_id got=%h exp=3", o_commit_cmt_id); end
        checks++; if (o_commit_grp_id !== 4'h4) begin failures++; $display("FAIL commit_grp got=%h exp=4", o_commit_grp_id); end
        i_entry_all_done = '0;
    endtask

    task automatic test_full_same_cycle();
        i_disp_valid = 1'b1;
        for (int k = 0; k < 3; k++) step();
        i_disp_valid = 1'b0;
        #1;
        checks++; if (o_rob_full !== 1'b1) begin failures++; $display("FAIL same_full got=%b exp=1", o_rob_full); end
        i_disp_valid = 1'b1; i_entry_all_done = 8'h08;
        #1;
        checks++; if (o_entry_load !== 8'h00) begin failures++; $display("FAIL same_load got=%h exp=00", o_entry_load); end
        checks++; if (o_commit_valid !== 1'b1) begin failures++; $display("FAIL same_cvalid got=%b exp=1", o_commit_valid); end
        step();
        i_disp_valid = 1'b0; i_entry_all_done = '0;
        #1;
        checks++; if (o_rob_full !== 1'b0) begin failures++; $display("FAIL same_notfull got=%b exp=0", o_rob_full); end
        checks++; if (o_alloc_cmt_id !== 4'hB) begin failures++; $display("FAIL same_inptr got=%h exp=b", o_alloc_cmt_id); end
        checks++; if (o_commit_cmt_id !== 4'h4) begin failures++; $display("FAIL same_outptr got=%h exp=4", o_commit_cmt_id); end
    endtask

    task automatic test_wrap();
        i_reset = 1'b1; step(); i_reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            i_disp_valid = 1'b1;
            #1;
            checks++; if (o_alloc_cmt_id !== cmt_id_t'(i)) begin failures++; $display("FAIL wrap_alloc i=%0d got=%h exp=%h", i, o_alloc_cmt_id, cmt_id_t'(i)); end
            step();
            i_disp_valid = 1'b0;
            #1;
            checks++; if (o_rob_empty !== 1'b0) begin failures++; $display("FAIL wrap_nonempty i=%0d got=%b exp=0", i, o_rob_empty); end
            i_entry_all_done = '1;
            #1;
            checks++; if (o_commit_valid !== 1'b1) begin failures++; $display("FAIL wrap_cvalid i=%0d got=%b exp=1", i, o_commit_valid); end
            checks++; if (o_commit_cmt_id !== cmt_id_t'(i)) begin failures++; $display("FAIL wrap_cid i=%0d got=%h exp=%h", i, o_commit_cmt_id, cmt_id_t'(i)); end
            checks++; if (o_commit_finish !== (CMT_ENTRY_SIZE'(1) << (i % 8))) begin failures++; $display("FAIL wrap_finish i=%0d got=%h exp=%h", i, o_commit_finish, CMT_ENTRY_SIZE'(1) << (i % 8)); end
            step();
            i_entry_all_done = '0;
            #1;
            checks++; if (o_rob_empty !== 1'b1) begin failures++; $display("FAIL wrap_empty i=%0d got=%b exp=1", i, o_rob_empty); end
        end
    endtask

    task automatic test_flush();
        i_disp_valid = 1'b1;
        step(); step();
        i_entry_all_done = '1; i_flush = 1'b1;
        #1;
        checks++; if (o_commit_valid !== 1'b0) begin failures++; $display("FAIL flush_cvalid got=%b exp=0", o_commit_valid); end
        checks++; if (o_entry_load !== 8'h00) begin failures++; $display("FAIL flush_load got=%h exp=00", o_entry_load); end
        checks++; if (o_disp_ready !== 1'b0) begin failures++; $display("FAIL flush_ready got=%b exp=0", o_disp_ready); end
        step();
        i_flush = 1'b0; i_disp_valid = 1'b0; i_entry_all_done = '0;
        #1;
        checks++; if (o_alloc_cmt_id !== 4'h0) begin failures++; $display("FAIL flush_inptr got=%h exp=0", o_alloc_cmt_id); end
        checks++; if (o_commit_cmt_id !== 4'h0) begin failures++; $display("FAIL flush_outptr got=%h exp=0", o_commit_cmt_id); end
        checks++; if (o_rob_empty !== 1'b1) begin failures++; $display("FAIL flush_empty got=%b exp=1", o_rob_empty); end
    endtask

    task automatic test_reset_mid();
        i_disp_valid = 1'b1;
        step(); step(); step();
        i_reset = 1'b1; i_entry_all_done = '1;
        step();
        i_reset = 1'b0; i_disp_valid = 1'b0; i_entry_all_done = '0;
        #1;
        checks++; if (o_alloc_cmt_id !== 4'h0) begin failures++; $display("FAIL rstmid_inptr got=%h exp=0", o_alloc_cmt_id); end
        checks++; if (o_commit_cmt_id !== 4'h0) begin failures++; $display("FAIL rstmid_outptr got=%h exp=0", o_commit_cmt_id); end
        checks++; if (o_rob_empty !== 1'b1) begin failures++; $display("FAIL rstmid_empty got=%b exp=1", o_rob_empty); end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_dispatch();
        test_full();
        test_commit();
        test_full_same_cycle();
        test_wrap();
        test_flush();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
